i2c_master_controller: RTL and testbench

I2C_MASTER_CONTROLLER -- requirements
Module: i2c_master_controller

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_qtr_tick.sv | 33 +++
 rtl/i2c_master_controller.sv | 158 +++++++++++++++
 tb/tb_i2c_master_controller.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared FSM state type and bus timing constants for the I2C master
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_NACK,
        STOP
    } i2c_state_t;

    localparam int START_QTRS = 2;
    localparam int BIT_QTRS   = 4;
    localparam int STOP_QTRS  = 3;
    localparam int I2C_ADDR_W = 7;

endpackage

// File: rtl/i2c_qtr_tick.sv
// rtl/i2c_qtr_tick.sv - quarter-period strobe generator with clear and stall
module i2c_qtr_tick #(
    parameter int QTR_DIV = 4
) (
    input  logic i2c_clk,
    input  logic i2c_rst_n,
    input  logic clear,
    input  logic stall,
    output logic tick
);

    localparam int CW = $clog2(QTR_DIV);

    logic [CW-1:0] cnt;

    // A stall only freezes the counter at the first cycle of a quarter.
    always_ff @(posedge i2c_clk or negedge i2c_rst_n) begin
        if (!i2c_rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (stall && (cnt == '0)) begin
            cnt <= cnt;
        end else if (cnt == CW'(QTR_DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clear && (cnt == CW'(QTR_DIV - 1));

endmodule

// File: rtl/i2c_master_controller.sv
// rtl/i2c_master_controller.sv - single-byte I2C master; I2C_MASTER_CLK_STRETCH_EN enables slave clock stretching
import i2c_pkg::*;

module i2c_master_controller #(
    parameter int QTR_DIV = 4
) (
    input  logic                  i2c_clk,
    input  logic                  i2c_rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [I2C_ADDR_W-1:0] cmd_addr,
    input  logic                  cmd_rw,
    input  logic [7:0]            cmd_wdata,
    output logic                  rsp_valid,
    output logic [7:0]            rsp_rdata,
    output logic                  rsp_nack,
    output logic                  i2c_scl,
    output logic                  i2c_sda_oe,
    input  logic                  i2c_sda_i,
    input  logic                  i2c_scl_i
);

    i2c_state_t state, state_nxt;
    logic [1:0] qtr;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] wdata_q;
    logic       rw_q;
    logic       tick;
    logic       stall;
    logic       bit_state;
    logic       last_qtr;
    logic       qtr_end;

    assign cmd_ready = (state == IDLE);
    assign bit_state = (state inside {ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_NACK});

`ifdef I2C_MASTER_CLK_STRETCH_EN
    assign stall = bit_state && (qtr == 2'd2) && !i2c_scl_i;
`else
    assign stall = 1'b0;
`endif

    i2c_qtr_tick #(.QTR_DIV(QTR_DIV)) u_qtr_tick (
        .i2c_clk   (i2c_clk),
        .i2c_rst_n (i2c_rst_n),
        .clear     (state == IDLE),
        .stall     (stall),
        .tick      (tick)
    );

    always_comb begin
        last_qtr = 1'b0;
        if (state == START)     last_qtr = (qtr == 2'(START_QTRS - 1));
        else if (state == STOP) last_qtr = (qtr == 2'(STOP_QTRS - 1));
        else if (bit_state)     last_qtr = (qtr == 2'(BIT_QTRS - 1));
    end

    assign qtr_end = tick && last_qtr;

    always_comb begin
        state_nxt  = state;
        i2c_scl    = 1'b1;
        i2c_sda_oe = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) state_nxt = START;
            end
            START: begin
                i2c_scl    = (qtr == 2'd0);
                i2c_sda_oe = 1'b1;
                if (qtr_end) state_nxt = ADDR;
            end
            ADDR: begin
                i2c_scl    = qtr[1];
                i2c_sda_oe = !shreg[7];
                if (qtr_end && (bit_cnt == 3'd7)) state_nxt = ADDR_ACK;
            end
            ADDR_ACK: begin
                i2c_scl = qtr[1];
                if (qtr_end) state_nxt = rsp_nack ? STOP : (rw_q ? RDATA : WDATA);
            end
            WDATA: begin
                i2c_scl    = qtr[1];
                i2c_sda_oe = !shreg[7];
                if (qtr_end && (bit_cnt == 3'd7)) state_nxt = WDATA_ACK;
            end
            WDATA_ACK: begin
                i2c_scl = qtr[1];
                if (qtr_end) state_nxt = STOP;
            end
            RDATA: begin
                i2c_scl = qtr[1];
                if (qtr_end && (bit_cnt == 3'd7)) state_nxt = RDATA_NACK;
            end
            RDATA_NACK: begin
                i2c_scl = qtr[1];
                if (qtr_end) state_nxt = STOP;
            end
            STOP: begin
                // SCL rises with SDA low, then SDA is released while SCL is high.
                i2c_scl    = (qtr != 2'd0);
                i2c_sda_oe = (qtr != 2'd2);
                if (qtr_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i2c_clk or negedge i2c_rst_n) begin
        if (!i2c_rst_n) begin
            state     <= IDLE;
            qtr       <= 2'd0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            wdata_q   <= 8'h00;
            rw_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_nack  <= 1'b0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= (state == STOP) && qtr_end;
            if (state == IDLE) begin
                qtr     <= 2'd0;
                bit_cnt <= 3'd0;
                if (cmd_valid) begin
                    shreg    <= {cmd_addr, cmd_rw};
                    wdata_q  <= cmd_wdata;
                    rw_q     <= cmd_rw;
                    rsp_nack <= 1'b0;
                end
            end else if (tick) begin
                qtr <= last_qtr ? 2'd0 : qtr + 2'd1;
                // SDA is sampled on the last cycle of the SCL-high quarter 2.
                if (qtr == 2'd2) begin
                    if (state == RDATA) shreg <= {shreg[6:0], i2c_sda_i};
                    if ((state == ADDR_ACK || state == WDATA_ACK) && i2c_sda_i) rsp_nack <= 1'b1;
                end
                if (last_qtr) begin
                    case (state)
                        ADDR, WDATA: begin
                            shreg   <= {shreg[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        RDATA: begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) rsp_rdata <= shreg;
                        end
                        ADDR_ACK: shreg <= wdata_q;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_controller.sv
// tb/tb_i2c_master_controller.sv - directed scoreboard bench with a behavioural I2C slave
module tb_i2c_master_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_addr;
    logic       cmd_rw;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       i2c_scl;
    logic       i2c_sda_oe;
    logic       i2c_scl_i;
    logic       slave_low;
    wire        sda_line = !(i2c_sda_oe || slave_low);

    i2c_master_controller #(.QTR_DIV(4)) dut (
        .i2c_clk    (clk),
        .i2c_rst_n  (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_rw     (cmd_rw),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_nack   (rsp_nack),
        .i2c_scl    (i2c_scl),
        .i2c_sda_oe (i2c_sda_oe),
        .i2c_sda_i  (sda_line),
        .i2c_scl_i  (i2c_scl_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       nack;
        logic       chk_rd;
        logic [7:0] rdata;
        int         lat;
    } exp_t;

    exp_t       exp_q[$];
    int         acc_q[$];
    logic [7:0] bus_q[$];
    int tests = 0, fails = 0;
    int cyc = 0, last_acc = -1, rsp_cnt = 0, b2b_cnt = 0;
    int start_cnt = 0, stop_cnt = 0, rises = 0, last_rises = 0;
    logic prev_rsp = 1'b0;

    logic       s_ack_addr, s_ack_data;
    logic [7:0] s_rdata;
    logic [7:0] sh;
    logic       prev_scl, prev_sda, rd_mode, acked, mack_lvl;
    int         bitn, byte_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Response monitor: pops the scoreboard on every rsp_valid pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                rsp_cnt++;
                chk("rsp_one_cycle", prev_rsp, 1'b0);
                chk("rsp_expected", (exp_q.size() > 0), 1'b1);
                if (exp_q.size() > 0 && acc_q.size() > 0) begin
                    exp_t e;
                    int   a;
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("rsp_latency", cyc + 1 - a, e.lat);
                    chk("rsp_nack", rsp_nack, e.nack);
                    if (e.chk_rd && !e.nack) chk("rsp_rdata", rsp_rdata, e.rdata);
                end
            end
            if (cmd_valid && cmd_ready) begin
                acc_q.push_back(cyc + 1);
                last_acc = cyc + 1;
                if (rsp_valid) b2b_cnt++;
            end
            prev_rsp = rsp_valid;
        end
    end

    // Behavioural slave: decodes START/STOP, collects bytes, drives ACKs and read data on SCL low.
    always @(negedge clk) begin
        if (!rst_n) begin
            bitn = 0; byte_idx = 0; slave_low = 1'b0;
            prev_scl = 1'b1; prev_sda = 1'b1;
        end else begin
            if (i2c_scl && prev_scl && prev_sda && !sda_line) begin
                start_cnt++; bitn = 0; byte_idx = 0; rises = 0; slave_low = 1'b0;
            end else if (i2c_scl && prev_scl && !prev_sda && sda_line) begin
                stop_cnt++; last_rises = rises - 1;
            end else if (i2c_scl && !prev_scl) begin
                rises++;
                if (bitn < 8) sh = {sh[6:0], sda_line};
                else if (byte_idx == 1) mack_lvl = sda_line;
                bitn++;
            end else if (!i2c_scl && prev_scl) begin
                if (bitn == 8) begin
                    bus_q.push_back(sh);
                    if (byte_idx == 0) begin
                        rd_mode = sh[0]; acked = s_ack_addr; slave_low = s_ack_addr;
                    end else if (!rd_mode) begin
                        slave_low = s_ack_data;
                    end else begin
                        slave_low = 1'b0;
                    end
                end else if (bitn == 9) begin
                    bitn = 0; byte_idx++;
                    slave_low = (byte_idx == 1 && rd_mode && acked) ? !s_rdata[7] : 1'b0;
                end else if (bitn > 0 && byte_idx == 1 && rd_mode && acked) begin
                    slave_low = !s_rdata[7 - bitn];
                end
            end
            prev_scl = i2c_scl;
            prev_sda = !(i2c_sda_oe || slave_low);
        end
    end

    task automatic issue(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                         input logic e_nack, input logic [7:0] e_rd, input int e_lat);
        exp_q.push_back('{nack: e_nack, chk_rd: rw, rdata: e_rd, lat: e_lat});
        cmd_addr = a; cmd_rw = rw; cmd_wdata = wd; cmd_valid = 1'b1;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        chk("accept_edge", last_acc, cyc);
        chk("nack_clear_on_accept", rsp_nack, 1'b0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        chk("done_timeout", exp_q.size(), 0);
        @(posedge clk); #2;
    endtask

    task automatic bus_chk(input string tag, input logic [7:0] exp);
        logic [8:0] obs;
        obs = 9'h1FF;
        if (bus_q.size() > 0) obs = {1'b0, bus_q.pop_front()};
        chk(tag, obs, {1'b0, exp});
    endtask

    initial begin
        int st0, sp0, r0, a0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_rw = 1'b0; cmd_wdata = '0;
        i2c_scl_i = 1'b1; s_ack_addr = 1'b1; s_ack_data = 1'b1; s_rdata = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 8'h00);
        chk("rst_rsp_nack", rsp_nack, 1'b0);
        chk("rst_scl", i2c_scl, 1'b1);
        chk("rst_sda_oe", i2c_sda_oe, 1'b0);

        // Write 0x55/0xA5 issued on the first edge after reset release.
        rst_n = 1'b1;
        sp0 = stop_cnt;
        issue(7'h55, 1'b0, 8'hA5, 1'b0, 8'h00, 309);
        wait_done();
        chk("wr_nbytes", bus_q.size(), 2);
        bus_chk("wr_addr_byte", 8'hAA);
        bus_chk("wr_data_byte", 8'hA5);
        chk("wr_stop_seen", stop_cnt - sp0, 1);
        chk("idle_scl", i2c_scl, 1'b1);
        chk("idle_sda_oe", i2c_sda_oe, 1'b0);

        // Read 0x55 returning 0x3C.
        s_rdata = 8'h3C; mack_lvl = 1'b0;
        issue(7'h55, 1'b1, 8'h00, 1'b0, 8'h3C, 309);
        wait_done();
        bus_chk("rd_addr_byte", 8'hAB);
        bus_chk("rd_data_byte", 8'h3C);
        chk("rd_master_nack", mack_lvl, 1'b1);
        repeat (20) @(posedge clk);
        #2;
        chk("rd_rdata_hold", rsp_rdata, 8'h3C);

        // Address NACK: STOP follows the ninth clock directly.
        s_ack_addr = 1'b0;
        issue(7'h12, 1'b0, 8'h77, 1'b1, 8'h00, 165);
        wait_done();
        chk("anack_clocks", last_rises, 9);
        bus_chk("anack_addr_byte", 8'h24);
        chk("anack_no_data", bus_q.size(), 0);
        repeat (10) @(posedge clk);
        #2;
        chk("anack_hold", rsp_nack, 1'b1);

        // Data NACK on an all-ones byte.
        s_ack_addr = 1'b1; s_ack_data = 1'b0;
        issue(7'h33, 1'b0, 8'hFF, 1'b1, 8'h00, 309);
        wait_done();
        bus_chk("dnack_addr_byte", 8'h66);
        bus_chk("dnack_data_byte", 8'hFF);

        // Read from the all-ones address.
        s_ack_data = 1'b1; s_rdata = 8'hC3;
        issue(7'h7F, 1'b1, 8'h00, 1'b0, 8'hC3, 309);
        wait_done();
        bus_chk("rd7f_addr_byte", 8'hFF);
        bus_chk("rd7f_data_byte", 8'hC3);

        // Back-to-back commands with cmd_valid held high.
        st0 = start_cnt; sp0 = stop_cnt; b2b_cnt = 0;
        exp_q.push_back('{nack: 1'b0, chk_rd: 1'b0, rdata: 8'h00, lat: 309});
        cmd_addr = 7'h21; cmd_rw = 1'b0; cmd_wdata = 8'h3C; cmd_valid = 1'b1;
        @(posedge clk); #2;
        exp_q.push_back('{nack: 1'b0, chk_rd: 1'b0, rdata: 8'h00, lat: 309});
        cmd_addr = 7'h40; cmd_wdata = 8'h81;
        for (int i = 0; i < 1000 && !cmd_ready; i++) @(negedge clk);
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        wait_done();
        chk("b2b_same_cycle", b2b_cnt, 1);
        chk("b2b_starts", start_cnt - st0, 2);
        chk("b2b_stops", stop_cnt - sp0, 2);
        bus_chk("b2b_addr0", 8'h42);
        bus_chk("b2b_data0", 8'h3C);
        bus_chk("b2b_addr1", 8'h80);
        bus_chk("b2b_data1", 8'h81);

`ifdef I2C_MASTER_CLK_STRETCH_EN
        // Slave holds SCL low for 20 cycles at the start of ADDR bit 3 quarter 2.
        exp_q.push_back('{nack: 1'b0, chk_rd: 1'b0, rdata: 8'h00, lat: 329});
        cmd_addr = 7'h55; cmd_rw = 1'b0; cmd_wdata = 8'hA5; cmd_valid = 1'b1;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        repeat (64) @(posedge clk);
        #2;
        i2c_scl_i = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        i2c_scl_i = 1'b1;
        wait_done();
        bus_chk("stretch_addr", 8'hAA);
        bus_chk("stretch_data", 8'hA5);
`endif

        // Reset in SCL-low half of WDATA bit 5.
        cmd_addr = 7'h2A; cmd_rw = 1'b0; cmd_wdata = 8'h5A; cmd_valid = 1'b1;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        a0 = cyc;
        chk("rst_mid_accept", last_acc, a0);
        repeat (233) @(posedge clk);
        #2;
        chk("rst_mid_busy", cmd_ready, 1'b0);
        chk("rst_mid_scl_low", i2c_scl, 1'b0);
        sp0 = stop_cnt; r0 = rsp_cnt;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_scl", i2c_scl, 1'b1);
        chk("rst_mid_sda_oe", i2c_sda_oe, 1'b0);
        chk("rst_mid_ready", cmd_ready, 1'b1);
        chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
        chk("rst_mid_rdata", rsp_rdata, 8'h00);
        chk("rst_mid_nack", rsp_nack, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        acc_q.delete(); bus_q.delete(); exp_q.delete();
        rst_n = 1'b1;
        repeat (400) @(posedge clk);
        #2;
        chk("rst_no_rsp", rsp_cnt, r0);
        chk("rst_no_stop", stop_cnt, sp0);
        chk("rst_after_scl", i2c_scl, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
